// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants for the overlay sprite ROM arbiter: default widths,
// requester slot assignment and where each image lives in the shared ROM.
package sprite_rom_arbiter_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int ROM_LAT_DEF = 1;
    localparam int STAT_W_DEF  = 16;

    localparam int REQ_START = 0;
    localparam int REQ_END   = 1;
    localparam int REQ_WIN   = 2;
    localparam int REQ_HEART = 3;

    // Page images are 160x120 RGB565, heart sprite follows the last page.
    localparam logic [ADDR_W_DEF-1:0] ROM_BASE_START = 16'h0000;
    localparam logic [ADDR_W_DEF-1:0] ROM_BASE_END   = 16'h4B00;
    localparam logic [ADDR_W_DEF-1:0] ROM_BASE_WIN   = 16'h9600;
    localparam logic [ADDR_W_DEF-1:0] ROM_BASE_HEART = 16'hE100;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0, take the
// lowest set bit, then rotate the result back into requester numbering.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner_oh,
    output logic [IDX_W-1:0] winner_idx
);

    logic [N-1:0]     req_rot;
    logic [N-1:0]     oh_rot;
    logic [IDX_W-1:0] enc;
    logic [IDX_W:0]   idx_sum;

    always_comb begin
        req_rot = '0;
        for (int j = 0; j < N; j++) begin
            req_rot[j] = req[(j + int'(ptr)) % N];
        end
    end

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        enc    = '0;
        oh_rot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                enc    = IDX_W'(i);
                oh_rot = N'(1) << i;
            end
        end
    end

    always_comb begin
        winner_oh = '0;
        for (int k = 0; k < N; k++) begin
            winner_oh[(k + int'(ptr)) % N] = oh_rot[k];
        end
    end

    assign idx_sum    = {1'b0, enc} + {1'b0, ptr};
    assign winner_idx = (idx_sum >= (IDX_W + 1)'(N)) ? IDX_W'(idx_sum - (IDX_W + 1)'(N))
                                                     : idx_sum[IDX_W-1:0];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one synchronous image ROM among the overlay
// requesters; read data returns tagged with the requester's one-hot ID.
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF,
    parameter int STAT_W  = STAT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr_stats,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy,
    output logic [STAT_W-1:0]       stall_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]              ptr_reg, ptr_next;
    logic [N_REQ-1:0]              gnt_reg;
    logic                          rom_en_reg;
    logic [ADDR_W-1:0]             rom_addr_reg;
    logic [STAT_W-1:0]             stall_reg, stall_next;
    logic [ROM_LAT-1:0][N_REQ-1:0] pipe_reg;

    logic [N_REQ-1:0]  win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              grant;
    logic              multi_req;
    logic              stall_cond;
    logic [ADDR_W-1:0] addr_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
        assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
    end

    rr_priority_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_reg),
        .winner_oh  (win_oh),
        .winner_idx (win_idx)
    );

    assign grant      = en && (req != '0);
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_req  = (req & (req - N_REQ'(1))) != '0;
    assign stall_cond = en ? multi_req : (req != '0);
    assign ptr_next   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    always_comb begin
        stall_next = stall_reg;
        if (clr_stats) begin
            stall_next = '0;
        end else if (stall_cond && (stall_reg != '1)) begin
            stall_next = stall_reg + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            gnt_reg      <= '0;
            rom_en_reg   <= 1'b0;
            rom_addr_reg <= '0;
            stall_reg    <= '0;
            pipe_reg     <= '0;
        end else begin
            gnt_reg    <= grant ? win_oh : '0;
            rom_en_reg <= grant;
            if (grant) begin
                rom_addr_reg <= addr_arr[win_idx];
                ptr_reg      <= ptr_next;
            end
            stall_reg   <= stall_next;
            pipe_reg[0] <= gnt_reg;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_reg[k] <= pipe_reg[k-1];
            end
        end
    end

    assign gnt       = gnt_reg;
    assign rom_en    = rom_en_reg;
    assign rom_addr  = rom_addr_reg;
    assign rd_valid  = pipe_reg[ROM_LAT-1];
    assign rd_data   = rom_data;
    assign busy      = |pipe_reg;
    assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter with a 3-cycle ROM: reference arbiter model,
// read-return scoreboard, a vector table and hand sequences for corner cases.
module tb_sprite_rom_arbiter;
    import sprite_rom_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;
    localparam int SW  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            clr_stats = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]    gnt;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic [SW-1:0]   stall_cnt;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (LAT),
        .STAT_W  (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_stats (clr_stats),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // ROM model with LAT cycles from rom_en to data
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_en ? rom_f(rom_addr) : '0;
        for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    typedef struct {
        int            due;
        logic [N-1:0]  oh;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic [N-1:0]  req;
        logic          en;
        logic [N-1:0]  exp_gnt;
        logic [SW-1:0] exp_stall;
    } vec_t;
    vec_t vecs[15];

    int            m_ptr;
    logic [SW-1:0] m_stall;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  m_gnt;
    logic          m_en;
    int            cycle = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic model_clear();
        m_ptr   = 0;
        m_stall = '0;
        m_addr  = '0;
        m_gnt   = '0;
        m_en    = 1'b0;
        sb.delete();
    endtask

    // Predict the decision for the current inputs, clock once, then compare.
    task automatic step();
        int      w;
        logic    exp_busy;
        rd_exp_t e;
        w     = -1;
        m_gnt = '0;
        if (en && req != '0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req[j]) w = j;
            end
        end
        m_en = (w >= 0);
        if (w >= 0) begin
            m_gnt[w] = 1'b1;
            m_addr   = addr[w*AW +: AW];
            m_ptr    = (w + 1) % N;
            sb.push_back('{due: cycle + 1 + LAT, oh: m_gnt, data: rom_f(m_addr)});
        end
        if (clr_stats) m_stall = '0;
        else if (((en && $countones(req) >= 2) || (!en && req != '0)) && m_stall != '1)
            m_stall = m_stall + 1'b1;

        @(posedge clk);
        #1;
        cycle++;
        chk("gnt", gnt, m_gnt);
        chk("rom_en", rom_en, m_en);
        chk("rom_addr", rom_addr, m_addr);
        chk("stall_cnt", stall_cnt, m_stall);
        exp_busy = 1'b0;
        foreach (sb[i]) if (sb[i].due - LAT < cycle) exp_busy = 1'b1;
        chk("busy", busy, exp_busy);
        if (sb.size() > 0 && sb[0].due == cycle) begin
            e = sb.pop_front();
            chk("rd_valid", rd_valid, e.oh);
            chk("rd_data", rd_data, e.data);
            $display("read cycle %0d: rd_valid=%b rd_data=%h", cycle, rd_valid, rd_data);
        end else begin
            chk("rd_valid_idle", rd_valid, '0);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        en        = 1'b0;
        clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic drain(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vecs[0]  = '{4'hF, 1'b1, 4'b0001, 16'd1};
        vecs[1]  = '{4'hF, 1'b1, 4'b0010, 16'd2};
        vecs[2]  = '{4'hF, 1'b1, 4'b0100, 16'd3};
        vecs[3]  = '{4'hF, 1'b1, 4'b1000, 16'd4};
        vecs[4]  = '{4'hF, 1'b1, 4'b0001, 16'd5};
        vecs[5]  = '{4'hF, 1'b1, 4'b0010, 16'd6};
        vecs[6]  = '{4'h5, 1'b1, 4'b0100, 16'd7};
        vecs[7]  = '{4'h5, 1'b1, 4'b0001, 16'd8};
        vecs[8]  = '{4'h5, 1'b0, 4'b0000, 16'd9};
        vecs[9]  = '{4'h5, 1'b0, 4'b0000, 16'd10};
        vecs[10] = '{4'h5, 1'b0, 4'b0000, 16'd11};
        vecs[11] = '{4'h5, 1'b0, 4'b0000, 16'd12};
        vecs[12] = '{4'h5, 1'b0, 4'b0000, 16'd13};
        vecs[13] = '{4'h5, 1'b1, 4'b0100, 16'd14};
        vecs[14] = '{4'h5, 1'b1, 4'b0001, 16'd15};

        addr[REQ_START*AW +: AW] = ROM_BASE_START + 16'h0040;
        addr[REQ_END*AW   +: AW] = ROM_BASE_END   + 16'h0031;
        addr[REQ_WIN*AW   +: AW] = 16'h1234;
        addr[REQ_HEART*AW +: AW] = ROM_BASE_HEART + 16'h0013;

        // Idle after reset
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Single request from the win page, dropped once granted
        req = 4'b0100;
        step();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_addr", rom_addr, 16'h1234);
        drain(LAT + 1);

        // Full contention then en gap, from a fresh pointer
        addr[REQ_WIN*AW +: AW] = ROM_BASE_WIN + 16'h0022;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req = vecs[i].req;
            en  = vecs[i].en;
            step();
            chk("tbl_gnt", gnt, vecs[i].exp_gnt);
            chk("tbl_stall", stall_cnt, vecs[i].exp_stall);
        end
        en = 1'b1;
        drain(LAT + 1);

        // Requester 3 withdraws before its turn; requester 0 gets back-to-back
        do_reset();
        en  = 1'b1;
        req = 4'b1001;
        step();
        req = 4'b0001;
        step();
        chk("withdraw_gnt", gnt, 4'b0001);
        drain(LAT + 1);

        // Asynchronous reset while a read is in flight
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        step();
        req = '0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, '0);
        chk("arst_rom_en", rom_en, 1'b0);
        chk("arst_rom_addr", rom_addr, '0);
        chk("arst_rd_valid", rd_valid, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_stall", stall_cnt, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        en = 1'b1;
        drain(LAT + 2);

        // Stall counter saturation and clear priority
        do_reset();
        en  = 1'b0;
        req = 4'b0001;
        repeat (65534) @(posedge clk);
        #1;
        m_stall = 16'hFFFE;
        chk("stall_pre_sat", stall_cnt, 16'hFFFE);
        en  = 1'b1;
        req = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_sat", stall_cnt, 16'hFFFF);
        end
        clr_stats = 1'b1;
        step();
        chk("stall_clr", stall_cnt, '0);
        clr_stats = 1'b0;
        drain(LAT + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous single-port image ROM among several VGA overlay requesters: start page, end page, win page and heart sprites. Each requester previously needed its own ROM copy; this block replaces those copies.
Requesters post a pixel address with a level request. The block grants one requester per cycle using round-robin, drives the ROM, and returns data tagged with the requester's one-hot ID after the ROM latency.
It sits between the overlay display modules and the single BRAM, in the pixel clock domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 16, ROM address width
DATA_W, 16, ROM word width (RGB565)
ROM_LAT, 1, ROM read latency in cycles from rom_en to valid rom_data (1..3)
STAT_W, 16, width of saturating stall counter

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  arbitration enable; 0 = issue no new grants
clr_stats  in  1  synchronous clear of stall_cnt
req  in  N_REQ  per-requester level request
addr  in  N_REQ*ADDR_W  flattened addresses; slice i = requester i
gnt  out  N_REQ  one-hot grant pulse, registered
rom_en  out  1  ROM read enable, registered
rom_addr  out  ADDR_W  ROM address, registered
rom_data  in  DATA_W  ROM read data
rd_valid  out  N_REQ  one-hot, marks rd_data as belonging to requester i
rd_data  out  DATA_W  equals rom_data, unregistered passthrough
busy  out  1  1 while any read is in flight in the latency pipe
stall_cnt  out  STAT_W  cycles in which at least one active request was not granted

Behaviour:
- Reset values: gnt=0, rom_en=0, rom_addr=0, rd_valid=0, busy=0, stall_cnt=0, RR pointer=0.
- Decision at each rising edge, using the sampled req/addr:
  - If en=1 and req≠0, winner = first set bit of req scanning from ptr upward, modulo N_REQ.
  - On a grant: gnt[winner]<=1, rom_en<=1, rom_addr<=addr[winner], ptr<=(winner+1) mod N_REQ.
  - Otherwise: gnt<=0, rom_en<=0, rom_addr holds, ptr holds.
- Handshake:
  - Requester holds req and addr stable until it sees gnt.
  - Minimum req-to-gnt latency is 1 cycle.
  - req still high in the gnt cycle counts as a new request. Back-to-back grants to the same requester occur only if no other requester is active.
  - Dropping req before grant withdraws the request; no grant is issued for it.
- Fairness: an active requester is granted within N_REQ decision cycles (en=1).
- Throughput: one grant per cycle maximum.
- Read return: rd_valid[i] asserts exactly ROM_LAT cycles after the gnt[i]/rom_en cycle, for one cycle. This uses an N_REQ-wide one-hot shift pipe of depth ROM_LAT.
- busy = OR of the pipe stages.
- en=0: no new grants; in-flight reads drain normally and rd_valid still fires. ptr holds.
- stall_cnt:
  - Increments on a decision edge when popcount(req)≥2 and en=1, or when req≠0 and en=0.
  - Saturates at all-ones.
  - clr_stats sets it to 0 and takes priority over increment.
- Asynchronous reset mid-read: pipe cleared, so the outstanding read never produces rd_valid.
- addr slices of non-requesting ports are don't-care.

Decomposition:
- Shared package holds:
  - N_REQ, ADDR_W, DATA_W defaults.
  - Requester index constants: REQ_START=0, REQ_END=1, REQ_WIN=2, REQ_HEART=3.
  - ROM base addresses per image.
- One sub-module, rr_priority_pick: combinational; inputs req and ptr; outputs one-hot winner and index. It rotates req by ptr, runs a priority encoder, then rotates back.

Test Plan:
- Reset release, req=0 for 10 cycles -> gnt=0, rom_en=0, rd_valid=0, stall_cnt=0.
- Single req[2]=1, addr[2]=0x1234, held 1 cycle then dropped -> gnt=0100 one cycle later, rom_addr=0x1234, rd_valid=0100 ROM_LAT cycles after gnt with rd_data=model ROM[0x1234].
- req=1111 held continuously, ptr=0 -> grants 0001,0010,0100,1000,0001… one per cycle; stall_cnt increments every cycle.
- req=0101, then en=0 for 5 cycles mid-stream -> no gnt during those cycles, last in-flight rd_valid still appears, stall_cnt +5; resume continues the round-robin from the held ptr.
- ROM_LAT=3, grant issued, rst_n pulsed low 1 cycle later -> all outputs 0 immediately; no rd_valid afterwards.
- Force stall_cnt to 0xFFFE under contention for 3 cycles -> reads 0xFFFF and holds; clr_stats=1 -> 0 next edge.
